// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the symbol-counting game: phase encoding, widths
// and the per-level play-length rule.
package game_pkg;

  localparam int SYM_W = 8;
  localparam int LVL_W = 4;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_PRE   = 3'd1,
    PH_PLAY  = 3'd2,
    PH_POST  = 3'd3,
    PH_JUDGE = 3'd4,
    PH_WIN   = 3'd5,
    PH_LOSE  = 3'd6
  } phase_e;

  // Signed 9-bit math so deep levels clamp to the floor instead of wrapping.
  function automatic logic [7:0] play_secs(
    input logic [LVL_W-1:0] lvl,
    input int               base_secs,
    input int               step_secs,
    input int               min_secs
  );
    logic signed [8:0] lvl_s;
    logic signed [8:0] min_s;
    logic signed [8:0] secs_s;
    lvl_s  = $signed({5'b00000, lvl});
    min_s  = 9'(min_secs);
    secs_s = 9'(base_secs) - 9'(step_secs) * (lvl_s - 9'sd1);
    if (secs_s < min_s) begin
      return min_s[7:0];
    end else begin
      return secs_s[7:0];
    end
  endfunction

endpackage

// File: rtl/level_sequencer_sec_timer.sv
// Loadable seconds down-counter; done flags the tick that consumes the last second.
module sec_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         done
);

  assign done = tick && (count == W'(1));

  // Load has priority so a phase change can reload on its ending tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != {W{1'b0}})) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game controller: sequences each level through countdown, play, post and
// judge, and tracks level and score until the game is won or lost.
module level_sequencer
  import game_pkg::*;
#(
  parameter int PRE_SECS       = 3,
  parameter int PLAY_SECS_BASE = 20,
  parameter int PLAY_SECS_STEP = 2,
  parameter int PLAY_SECS_MIN  = 8,
  parameter int NUM_LEVELS     = 9
) (
  input  logic             Clk100M,
  input  logic             Reset,
  input  logic             secTick,
  input  logic             startBtn,
  input  logic             levelComplete,
  input  logic [SYM_W-1:0] magicSymbolCount,
  input  logic             guessValid,
  input  logic [SYM_W-1:0] playerGuess,
  output logic             genEnable,
  output logic             postSig,
  output logic [2:0]       phase,
  output logic [LVL_W-1:0] level,
  output logic [7:0]       timeLeft,
  output logic [7:0]       score,
  output logic             guessCorrect,
  output logic             gameOver,
  output logic             gameWon
);

  phase_e           state_r;
  logic             entry_r;
  logic [SYM_W-1:0] guess_r;
  logic             guess_vld_r;
  logic [LVL_W-1:0] level_r;
  logic [7:0]       score_r;
  logic             post_r;
  logic             correct_r;

  logic             tick_en_s;
  logic             done_s;
  logic             load_s;
  logic [7:0]       load_val_s;
  logic [7:0]       count_s;
  logic             judge_ok_s;
  logic             last_level_s;

  // entry_r marks the first cycle of a state, when the timer has just been loaded.
  assign tick_en_s    = ((state_r == PH_PRE) || (state_r == PH_PLAY)) && !entry_r && secTick;
  assign judge_ok_s   = guess_vld_r && (guess_r == magicSymbolCount);
  assign last_level_s = (level_r == LVL_W'(NUM_LEVELS));

  sec_timer #(.W(8)) u_timer (
    .clk      (Clk100M),
    .rst      (Reset),
    .load     (load_s),
    .load_val (load_val_s),
    .tick     (tick_en_s),
    .count    (count_s),
    .done     (done_s)
  );

  // Timer reload value for whichever phase is about to be entered.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = 8'd0;
    case (state_r)
      PH_IDLE, PH_WIN, PH_LOSE: begin
        if (startBtn) begin
          load_s     = 1'b1;
          load_val_s = 8'(PRE_SECS);
        end else begin
          load_s     = 1'b0;
        end
      end
      PH_PRE: begin
        if (done_s) begin
          load_s     = 1'b1;
          load_val_s = play_secs(level_r, PLAY_SECS_BASE, PLAY_SECS_STEP, PLAY_SECS_MIN);
        end else begin
          load_s     = 1'b0;
        end
      end
      PH_PLAY: begin
        if (done_s) begin
          load_s     = 1'b1;
          load_val_s = 8'd0;
        end else begin
          load_s     = 1'b0;
        end
      end
      PH_JUDGE: begin
        if (judge_ok_s && !last_level_s) begin
          load_s     = 1'b1;
          load_val_s = 8'(PRE_SECS);
        end else begin
          load_s     = 1'b0;
        end
      end
      default: begin
        load_s     = 1'b0;
        load_val_s = 8'd0;
      end
    endcase
  end

  // Phase sequencing, guess capture and level/score bookkeeping.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_r     <= PH_IDLE;
      entry_r     <= 1'b0;
      guess_r     <= {SYM_W{1'b0}};
      guess_vld_r <= 1'b0;
      level_r     <= {LVL_W{1'b0}};
      score_r     <= 8'd0;
      post_r      <= 1'b0;
      correct_r   <= 1'b0;
    end else begin
      entry_r   <= 1'b0;
      post_r    <= 1'b0;
      correct_r <= 1'b0;
      case (state_r)
        PH_IDLE, PH_WIN, PH_LOSE: begin
          if (startBtn) begin
            state_r <= PH_PRE;
            entry_r <= 1'b1;
            level_r <= LVL_W'(1);
            score_r <= 8'd0;
          end
        end
        PH_PRE: begin
          if (done_s) begin
            state_r <= PH_PLAY;
            entry_r <= 1'b1;
          end
        end
        PH_PLAY: begin
          if (done_s) begin
            state_r     <= PH_POST;
            entry_r     <= 1'b1;
            post_r      <= 1'b1;
            guess_r     <= {SYM_W{1'b0}};
            guess_vld_r <= 1'b0;
          end
        end
        PH_POST: begin
          if (guessValid) begin
            guess_r     <= playerGuess;
            guess_vld_r <= 1'b1;
          end
          if (levelComplete) begin
            state_r <= PH_JUDGE;
            entry_r <= 1'b1;
          end
        end
        PH_JUDGE: begin
          entry_r <= 1'b1;
          if (judge_ok_s) begin
            correct_r <= 1'b1;
            score_r   <= (score_r == 8'd255) ? 8'd255 : score_r + 8'd1;
            if (last_level_s) begin
              state_r <= PH_WIN;
            end else begin
              state_r <= PH_PRE;
              level_r <= level_r + LVL_W'(1);
            end
          end else begin
            state_r <= PH_LOSE;
          end
        end
        default: begin
          state_r <= PH_IDLE;
        end
      endcase
    end
  end

  assign phase        = state_r;
  assign level        = level_r;
  assign timeLeft     = count_s;
  assign score        = score_r;
  assign postSig      = post_r;
  assign guessCorrect = correct_r;
  assign genEnable    = (state_r == PH_PLAY);
  assign gameOver     = (state_r == PH_WIN) || (state_r == PH_LOSE);
  assign gameWon      = (state_r == PH_WIN);

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed table, level walk-through
// and random stimulus against a game-rule reference model.
module tb_level_sequencer;

  logic       Clk100M = 1'b0;
  logic       Reset, secTick, startBtn, levelComplete, guessValid;
  logic [7:0] magicSymbolCount, playerGuess;
  logic       genEnable, postSig, guessCorrect, gameOver, gameWon;
  logic [2:0] phase;
  logic [3:0] level;
  logic [7:0] timeLeft, score;

  int checks   = 0;
  int failures = 0;

  // reference model state: phase numbers follow the published encoding
  int m_phase = 0, m_level = 0, m_time = 0, m_score = 0, m_guess = 0;
  bit m_has = 1'b0, m_fresh = 1'b0, m_post = 1'b0, m_correct = 1'b0;

  int play_exp [9] = '{20, 18, 16, 14, 12, 10, 8, 8, 8};

  typedef struct {
    bit rst; bit st; bit tk;
    int e_phase; int e_tl; int e_level; int e_gen;
  } vec_t;
  vec_t vecs [9];

  level_sequencer dut (
    .Clk100M(Clk100M), .Reset(Reset), .secTick(secTick), .startBtn(startBtn),
    .levelComplete(levelComplete), .magicSymbolCount(magicSymbolCount),
    .guessValid(guessValid), .playerGuess(playerGuess), .genEnable(genEnable),
    .postSig(postSig), .phase(phase), .level(level), .timeLeft(timeLeft),
    .score(score), .guessCorrect(guessCorrect), .gameOver(gameOver), .gameWon(gameWon)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_play_secs(input int l);
    int v;
    v = 20 - 2 * (l - 1);
    return (v < 8) ? 8 : v;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit tk, input bit lc,
                            input bit gv, input int pg, input int mg);
    bit counting;
    counting  = (m_phase == 1 || m_phase == 2) && !m_fresh;
    m_post    = 1'b0;
    m_correct = 1'b0;
    m_fresh   = 1'b0;
    if (rst) begin
      m_phase = 0; m_level = 0; m_time = 0; m_score = 0; m_guess = 0; m_has = 1'b0;
    end else if (m_phase == 0 || m_phase == 5 || m_phase == 6) begin
      if (st) begin
        m_phase = 1; m_level = 1; m_score = 0; m_time = 3; m_fresh = 1'b1;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (counting && tk) begin
        if (m_time == 1) begin
          m_fresh = 1'b1;
          if (m_phase == 1) begin
            m_phase = 2; m_time = ref_play_secs(m_level);
          end else begin
            m_phase = 3; m_time = 0; m_post = 1'b1; m_has = 1'b0; m_guess = 0;
          end
        end else begin
          m_time = m_time - 1;
        end
      end
    end else if (m_phase == 3) begin
      if (gv) begin
        m_guess = pg; m_has = 1'b1;
      end
      if (lc) begin
        m_phase = 4; m_fresh = 1'b1;
      end
    end else begin
      m_fresh = 1'b1;
      if (m_has && m_guess == mg) begin
        m_correct = 1'b1;
        m_score   = (m_score + 1 > 255) ? 255 : m_score + 1;
        if (m_level == 9) m_phase = 5;
        else begin
          m_level = m_level + 1; m_phase = 1; m_time = 3;
        end
      end else begin
        m_phase = 6;
      end
    end
  endtask

  task automatic compare_model();
    check("phase", phase, m_phase);
    check("level", level, m_level);
    check("timeLeft", timeLeft, m_time);
    check("score", score, m_score);
    check("genEnable", genEnable, (m_phase == 2) ? 1 : 0);
    check("postSig", postSig, m_post);
    check("guessCorrect", guessCorrect, m_correct);
    check("gameOver", gameOver, (m_phase == 5 || m_phase == 6) ? 1 : 0);
    check("gameWon", gameWon, (m_phase == 5) ? 1 : 0);
  endtask

  // one clock: inputs held across the edge, outputs sampled 1 ns later
  task automatic drive(input bit rst, input bit st, input bit tk, input bit lc,
                       input bit gv, input logic [7:0] pg);
    Reset = rst; startBtn = st; secTick = tk; levelComplete = lc;
    guessValid = gv; playerGuess = pg;
    @(posedge Clk100M);
    model_step(rst, st, tk, lc, gv, int'(pg), int'(magicSymbolCount));
    #1;
    compare_model();
    Reset = 1'b0; startBtn = 1'b0; secTick = 1'b0; levelComplete = 1'b0; guessValid = 1'b0;
  endtask

  // enters in the first PRE cycle; mode 0 guess then complete, 1 same cycle, 2 no guess
  task automatic run_level(input int lvl, input int mode);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("pre_entry_tick", timeLeft, 3);
    repeat (2) drive(0, 0, 1, 0, 0, 8'd0);
    check("pre_last", timeLeft, 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("play_phase", phase, 2);
    check("play_load", timeLeft, play_exp[lvl-1]);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("play_entry_tick", timeLeft, play_exp[lvl-1]);
    repeat (play_exp[lvl-1] - 1) drive(0, 0, 1, 0, 0, 8'd0);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("post_entry", phase, 3);
    check("post_pulse", postSig, 1);
    if (mode == 0) begin
      drive(0, 0, 0, 0, 1, 8'd12);
      drive(0, 0, 0, 1, 0, 8'd0);
    end else if (mode == 1) begin
      drive(0, 0, 0, 1, 1, 8'd12);
    end else begin
      drive(0, 0, 0, 1, 0, 8'd0);
    end
    check("judge_phase", phase, 4);
    drive(0, 0, 0, 0, 0, 8'd0);
    check("after_judge", phase, (mode == 2) ? 6 : ((lvl == 9) ? 5 : 1));
    check("correct_pulse", guessCorrect, (mode == 2) ? 0 : 1);
  endtask

  initial begin
    Reset = 1'b1; startBtn = 1'b0; secTick = 1'b0; levelComplete = 1'b0;
    guessValid = 1'b0; playerGuess = 8'd0; magicSymbolCount = 8'd12;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1, 3, 1, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1, 3, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1, 2, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1, 1, 1, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 2, 20, 1, 1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 2, 20, 1, 1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2, 20, 1, 1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 2, 19, 1, 1};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].tk, 0, 0, 8'd0);
      check($sformatf("vec%0d_phase", i), phase, vecs[i].e_phase);
      check($sformatf("vec%0d_time", i), timeLeft, vecs[i].e_tl);
      check($sformatf("vec%0d_level", i), level, vecs[i].e_level);
      check($sformatf("vec%0d_gen", i), genEnable, vecs[i].e_gen);
    end

    repeat (18) drive(0, 0, 1, 0, 0, 8'd0);
    check("l1_time_last", timeLeft, 1);
    drive(0, 0, 1, 0, 0, 8'd0);
    check("l1_post", postSig, 1);
    check("l1_gen_off", genEnable, 0);
    drive(0, 0, 0, 0, 0, 8'd0);
    check("l1_post_once", postSig, 0);
    drive(0, 0, 0, 0, 1, 8'd12);
    drive(0, 0, 0, 1, 0, 8'd0);
    drive(0, 0, 0, 0, 0, 8'd0);
    check("l1_correct", guessCorrect, 1);
    check("l1_score", score, 1);
    check("l1_level", level, 2);
    check("l1_pre", phase, 1);
    drive(0, 0, 0, 0, 0, 8'd0);
    repeat (3) drive(0, 0, 1, 0, 0, 8'd0);
    check("l2_play_load", timeLeft, 18);
    drive(0, 0, 1, 0, 0, 8'd0);
    repeat (18) drive(0, 0, 1, 0, 0, 8'd0);
    drive(0, 0, 0, 0, 1, 8'd11);
    drive(0, 0, 0, 1, 0, 8'd0);
    drive(0, 0, 0, 0, 0, 8'd0);
    check("lose_phase", phase, 6);
    check("lose_over", gameOver, 1);
    check("lose_won", gameWon, 0);
    check("lose_level", level, 2);
    check("lose_score", score, 1);

    drive(0, 1, 0, 0, 0, 8'd0);
    for (int l = 1; l <= 9; l++) run_level(l, (l == 3) ? 1 : 0);
    check("win_score", score, 9);
    check("win_won", gameWon, 1);
    check("win_level", level, 9);
    drive(0, 1, 0, 0, 0, 8'd0);
    check("restart_level", level, 1);
    check("restart_score", score, 0);
    check("restart_phase", phase, 1);
    run_level(1, 2);
    check("noguess_lose", gameWon, 0);

    drive(0, 1, 0, 0, 0, 8'd0);
    repeat (4) drive(0, 0, 1, 0, 0, 8'd0);
    drive(0, 0, 1, 0, 0, 8'd0);
    repeat (11) drive(0, 0, 1, 0, 0, 8'd0);
    check("midplay_time", timeLeft, 9);
    drive(1, 0, 0, 0, 0, 8'd0);
    check("rst_phase", phase, 0);
    check("rst_gen", genEnable, 0);
    check("rst_time", timeLeft, 0);
    drive(0, 1, 0, 0, 0, 8'd0);
    check("rst_restart_level", level, 1);
    check("rst_restart_time", timeLeft, 3);

    for (int n = 0; n < 6000; n++) begin
      logic [7:0] pg;
      if ($urandom_range(0, 49) == 0) magicSymbolCount = 8'($urandom_range(0, 15));
      pg = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : magicSymbolCount;
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 5) == 0, pg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
